// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the scanning one-hot decoder.
// Holds the mode encodings and the dwell counter width function.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int dwell_cnt_w(input int dwell);
        if (dwell <= 2) return 1;
        return $clog2(dwell);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the scan decoder: counts 0..DWELL-1 while inc is high.
// tick marks the last dwell cycle; the count then returns to 0.
module dwell_timer
    import decoder_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tick
);

    localparam int CW = dwell_cnt_w(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_cnt;

    assign tick = inc && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= tick ? '0 : r_cnt + ONE;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with DIRECT select and timed SCAN sweep.
// Define DECODER_SCAN_WRAP_EN to add the wrap pulse output.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [(1<<SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      cur_sel
`ifdef DECODER_SCAN_WRAP_EN
    ,
    output logic                  wrap
`endif
);

    localparam int N = 1 << SEL_W;
    localparam logic [N-1:0]     Y_ONE   = N'(1);
    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_MAX = '1;

    logic [N-1:0]     r_y;
    logic [SEL_W-1:0] r_cur_sel;
    logic             r_wrap;
    // After reset nothing has been shown yet, so the first scan cycle
    // displays index 0 without consuming a dwell step.
    logic             r_fresh;

    logic             w_direct;
    logic             w_scan;
    logic             w_inc;
    logic             w_tick;
    logic [SEL_W-1:0] w_next;

    assign w_direct = en && (mode == MODE_DIRECT);
    assign w_scan   = en && (mode == MODE_SCAN);
    assign w_inc    = w_scan && !r_fresh;
    assign w_next   = r_cur_sel + SEL_ONE;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_direct),
        .inc  (w_inc),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= '0;
            r_cur_sel <= '0;
            r_wrap    <= 1'b0;
            r_fresh   <= 1'b1;
        end else if (!en) begin
            r_y    <= '0;
            r_wrap <= 1'b0;
        end else if (w_direct) begin
            r_y       <= Y_ONE << sel;
            r_cur_sel <= sel;
            r_wrap    <= 1'b0;
            r_fresh   <= 1'b0;
        end else begin
            r_fresh <= 1'b0;
            if (w_tick) begin
                r_y       <= Y_ONE << w_next;
                r_cur_sel <= w_next;
                r_wrap    <= (r_cur_sel == SEL_MAX);
            end else begin
                r_y    <= Y_ONE << r_cur_sel;
                r_wrap <= 1'b0;
            end
        end
    end

    assign y       = r_y;
    assign cur_sel = r_cur_sel;

`ifdef DECODER_SCAN_WRAP_EN
    assign wrap = r_wrap;
`else
    logic w_wrap_unused;
    assign w_wrap_unused = r_wrap;
`endif

endmodule

// File: tb/tb_decoder_scan.sv
// Directed table-driven bench for decoder_scan (SEL_W=2, DWELL=4),
// plus a DWELL=1 instance for the every-cycle rotation case.
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] y;
    logic [1:0] cur_sel;
    logic       wrap;
    logic [3:0] y1;
    logic [1:0] cur_sel1;
    logic       wrap1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef DECODER_SCAN_WRAP_EN
    localparam bit HAS_WRAP = 1'b1;
`else
    localparam bit HAS_WRAP = 1'b0;
    assign wrap  = 1'b0;
    assign wrap1 = 1'b0;
`endif

    decoder_scan #(.SEL_W(2), .DWELL(4)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .sel     (sel),
        .y       (y),
        .cur_sel (cur_sel)
`ifdef DECODER_SCAN_WRAP_EN
        ,
        .wrap    (wrap)
`endif
    );

    decoder_scan #(.SEL_W(2), .DWELL(1)) u_d1 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .sel     (sel),
        .y       (y1),
        .cur_sel (cur_sel1)
`ifdef DECODER_SCAN_WRAP_EN
        ,
        .wrap    (wrap1)
`endif
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] y;
        logic [1:0] cur;
        logic       wrap;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm,
                         input logic [3:0] gy, input logic [1:0] gc,
                         input logic gw,
                         input logic [3:0] ey, input logic [1:0] ec,
                         input logic ew);
        logic gwm;
        logic ewm;
        gwm = gw & HAS_WRAP;
        ewm = ew & HAS_WRAP;
        n_chk++;
        if (gy !== ey || gc !== ec || gwm !== ewm) begin
            n_err++;
            $display("FAIL %s: got y=%b cur=%0d wrap=%b, want y=%b cur=%0d wrap=%b",
                     nm, gy, gc, gwm, ey, ec, ewm);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0; sel = 2'd2;

        tbl.push_back('{"rst0",   1,1,0,2'd2, 4'b0000,2'd0,0});
        tbl.push_back('{"rst1",   1,1,0,2'd2, 4'b0000,2'd0,0});
        tbl.push_back('{"rel",    0,1,0,2'd2, 4'b0100,2'd2,0});
        tbl.push_back('{"dir0",   0,1,0,2'd0, 4'b0001,2'd0,0});
        tbl.push_back('{"dir1",   0,1,0,2'd1, 4'b0010,2'd1,0});
        tbl.push_back('{"dir2",   0,1,0,2'd2, 4'b0100,2'd2,0});
        tbl.push_back('{"dir3",   0,1,0,2'd3, 4'b1000,2'd3,0});
        tbl.push_back('{"scn3a",  0,1,1,2'd1, 4'b1000,2'd3,0});
        tbl.push_back('{"scn3b",  0,1,1,2'd1, 4'b1000,2'd3,0});
        tbl.push_back('{"scn3c",  0,1,1,2'd1, 4'b1000,2'd3,0});
        tbl.push_back('{"wrap",   0,1,1,2'd1, 4'b0001,2'd0,1});
        tbl.push_back('{"scn0b",  0,1,1,2'd2, 4'b0001,2'd0,0});
        tbl.push_back('{"scn0c",  0,1,1,2'd2, 4'b0001,2'd0,0});
        tbl.push_back('{"scn0d",  0,1,1,2'd2, 4'b0001,2'd0,0});
        tbl.push_back('{"scn1a",  0,1,1,2'd0, 4'b0010,2'd1,0});
        tbl.push_back('{"scn1b",  0,1,1,2'd0, 4'b0010,2'd1,0});
        tbl.push_back('{"enoff1", 0,0,1,2'd3, 4'b0000,2'd1,0});
        tbl.push_back('{"enoff2", 0,0,1,2'd3, 4'b0000,2'd1,0});
        tbl.push_back('{"enoff3", 0,0,1,2'd3, 4'b0000,2'd1,0});
        tbl.push_back('{"scn1c",  0,1,1,2'd3, 4'b0010,2'd1,0});
        tbl.push_back('{"scn1d",  0,1,1,2'd3, 4'b0010,2'd1,0});
        tbl.push_back('{"scn2a",  0,1,1,2'd3, 4'b0100,2'd2,0});
        tbl.push_back('{"rstscn", 1,1,1,2'd3, 4'b0000,2'd0,0});
        tbl.push_back('{"rs0a",   0,1,1,2'd3, 4'b0001,2'd0,0});
        tbl.push_back('{"rs0b",   0,1,1,2'd3, 4'b0001,2'd0,0});
        tbl.push_back('{"rs0c",   0,1,1,2'd3, 4'b0001,2'd0,0});
        tbl.push_back('{"rs0d",   0,1,1,2'd3, 4'b0001,2'd0,0});
        tbl.push_back('{"rs1a",   0,1,1,2'd3, 4'b0010,2'd1,0});
        tbl.push_back('{"exit",   0,1,0,2'd3, 4'b1000,2'd3,0});
        tbl.push_back('{"reent",  0,1,1,2'd0, 4'b1000,2'd3,0});
        tbl.push_back('{"rstpri", 1,0,1,2'd2, 4'b0000,2'd0,0});
        tbl.push_back('{"endir",  0,0,0,2'd1, 4'b0000,2'd0,0});
        tbl.push_back('{"dirres", 0,1,0,2'd1, 4'b0010,2'd1,0});

        foreach (tbl[i]) begin
            rst  = tbl[i].rst;
            en   = tbl[i].en;
            mode = tbl[i].mode;
            sel  = tbl[i].sel;
            step();
            check(tbl[i].name, y, cur_sel, wrap,
                  tbl[i].y, tbl[i].cur, tbl[i].wrap);
        end

        // DWELL=1 instance: reset, then rotate every cycle in SCAN.
        rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd3;
        step();
        check("d1_rst", y1, cur_sel1, wrap1, 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            logic [1:0] ec;
            logic [3:0] ey;
            logic       ew;
            ec = 2'(i % 4);
            ey = 4'b0001 << ec;
            ew = (i > 0) && (ec == 2'd0);
            step();
            check($sformatf("d1_rot%0d", i), y1, cur_sel1, wrap1,
                  ey, ec, ew);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter SEL_W, default 2: select width; the decoder has 2**SEL_W outputs; legal range 1..6.
REQ-002 Parameter DWELL, default 4: cycles each output stays active in scan mode; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port en  input  1  enable; 0 forces all outputs inactive and freezes scan state.
REQ-006 Port mode  input  1  0 = DIRECT decode of sel, 1 = SCAN auto-sweep.
REQ-007 Port sel  input  SEL_W  address decoded in DIRECT mode.
REQ-008 Port y  output  2**SEL_W  registered one-hot decoder output.
REQ-009 Port cur_sel  output  SEL_W  registered index of the currently active output.
REQ-010 Port wrap  output  1  one-cycle pulse when scan wraps from index 2**SEL_W-1 to 0; present only under DECODER_SCAN_WRAP_EN.

Function
REQ-011 y shall always be all-zero or exactly one-hot, with y[cur_sel] as the only permitted set bit.
REQ-012 DIRECT mode (en=1, mode=0): edge k samples sel, and from edge k y=1<<sel and cur_sel=sel (one-cycle latency); the dwell count clears to 0.
REQ-013 SCAN mode (en=1, mode=1): y=1<<cur_sel; the dwell count increments each cycle; at count DWELL-1 cur_sel advances by 1 modulo 2**SEL_W and the count returns to 0.
REQ-014 Entry into SCAN (mode 0->1) shall continue from the current cur_sel with the dwell count at 0, so the first output dwells the full DWELL cycles; sel is ignored in SCAN.
REQ-015 Exit from SCAN (mode 1->0) shall take effect at the next edge, with y decoding sel and the dwell count cleared.
REQ-016 DWELL=1 shall advance cur_sel every cycle in SCAN.
REQ-017 With en=0, y shall go to 0 at the next edge while cur_sel and the dwell count hold; on reassertion, y shall resume from the held cur_sel and count with no skipped or repeated output.
REQ-018 wrap shall assert for exactly the one cycle in which cur_sel registers 0 after the transition from 2**SEL_W-1 in SCAN, and never in DIRECT mode.
REQ-019 Counter arithmetic shall be unsigned with natural modulo-2**SEL_W wrap of cur_sel; the dwell counter width shall be the minimum needed to hold DWELL-1 (1 bit minimum).

Reset
REQ-020 With rst=1 at an edge, y=0, cur_sel=0, the dwell count is 0 and wrap=0, regardless of en, mode or sel.
REQ-021 rst mid-scan shall abandon the scan, and after release the sequence shall restart at index 0 with a full dwell.
REQ-022 rst shall take priority over en and mode in the same cycle.

Configuration
REQ-023 Macro DECODER_SCAN_WRAP_EN defined: the wrap port and its logic exist as per REQ-018.
REQ-024 Macro DECODER_SCAN_WRAP_EN undefined: the wrap port is absent and all other behaviour is identical.

Structure
REQ-025 Shared package decoder_pkg shall hold the mode constants MODE_DIRECT=0 and MODE_SCAN=1 and a function returning the dwell counter width for a given DWELL.
REQ-026 The dwell counter shall be sub-module dwell_timer (ports: clk, rst, clr, inc, tick); decoder_scan owns cur_sel, y and wrap.

Verification (SEL_W=2, DWELL=4, DECODER_SCAN_WRAP_EN defined)
REQ-027 rst=1 for 2 cycles, then en=1, mode=0, sel=2 -> y=0000 during reset, and y=0100, cur_sel=2 one edge after release.
REQ-028 DIRECT sweep with sel=0,1,2,3 on successive cycles -> y=0001,0010,0100,1000, each lagging sel by one cycle, with wrap=0 throughout.
REQ-029 Switch to SCAN from cur_sel=3 for 20 cycles -> y=1000 for 4 cycles, then 0001, 0010 and 0100 for 4 cycles each; wrap pulses once, in the first cycle of y=0001.
REQ-030 In SCAN after the 2nd of 4 cycles at y=0010, drop en for 3 cycles -> y=0000 for 3 cycles, then y=0010 for 2 more cycles, then y=0100.
REQ-031 rst during y=0100 in SCAN -> y=0000; after release with mode=1, y=0001 for 4 full cycles with no wrap pulse.
REQ-032 Rebuild with DWELL=1 and run SCAN -> y rotates every cycle and wrap pulses every 4th cycle.
